// File: rtl/ysyx_22040895_lsu.sv
// ysyx_22040895_lsu -- load/store unit between EXU and WBU.
//
// Takes one op at a time from EXU, issues at most one memory transaction on
// a valid/ready request bus, then aligns and extends load data. The 64-bit
// writeback value goes to WBU through a valid/ready output handshake.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   in_valid_i      EXU presents an op
//   in_ready_o      LSU can accept an op (IDLE only)
//   sl_i            00 pass-through, 01 load, 10 store, 11 treated as pass-through
//   size_i          00 byte, 01 half, 10 word, 11 dword
//   unsigned_i      zero-extend (1) or sign-extend (0) loads
//   result_i        EXU result: address for load/store, writeback value otherwise
//   mdata_i         store data, low bytes significant
//   mem_req_o       memory request valid, held until mem_gnt_i
//   mem_gnt_i       memory accepts the request
//   mem_we_o        1 store, 0 load
//   mem_addr_o      8-byte aligned address
//   mem_wdata_o     store data shifted into its byte lanes
//   mem_wmask_o     byte strobes
//   mem_rvalid_i    one-cycle response (load data or store ack)
//   mem_rdata_i     aligned 8-byte load data
//   out_valid_o     writeback value valid, held until out_ready_i
//   out_ready_i     WBU accepts
//   out_data_o      extended load data, result_i for pass-through, 0 for store
//   err_o           qualifies out_valid_o: misaligned access or response timeout

module ysyx_22040895_lsu #(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [1:0]  sl_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [63:0] result_i,
    input  logic [63:0] mdata_i,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic [7:0]  mem_wmask_o,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rdata_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] out_data_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    // Last WAIT count before giving up: 2**TIMEOUT_W-1 WAIT cycles in total.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t state, state_next;

    logic                 is_load, is_store, is_mem, misaligned, accept, timeout_hit;
    logic [7:0]           base_mask;
    logic [1:0]           size_q;
    logic                 unsigned_q, store_q;
    logic [2:0]           off_q;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic [63:0]          lane, load_ext;

    assign in_ready_o  = (state == S_IDLE);
    assign accept      = in_valid_i & in_ready_o;
    assign is_load     = (sl_i == 2'b01);
    assign is_store    = (sl_i == 2'b10);
    assign is_mem      = is_load | is_store;
    assign timeout_hit = (wait_cnt == CNT_LAST);

    always_comb begin
        misaligned = 1'b0;
        base_mask  = 8'h01;
        case (size_i)
            2'b00: begin misaligned = 1'b0;                   base_mask = 8'h01; end
            2'b01: begin misaligned = result_i[0];            base_mask = 8'h03; end
            2'b10: begin misaligned = |result_i[1:0];         base_mask = 8'h0F; end
            default: begin misaligned = |result_i[2:0];       base_mask = 8'hFF; end
        endcase
    end

    // Load alignment: shift the addressed byte lane down, truncate, extend.
    always_comb begin
        lane     = mem_rdata_i >> {off_q, 3'b000};
        load_ext = lane;
        case (size_q)
            2'b00: load_ext = unsigned_q ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            2'b01: load_ext = unsigned_q ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            2'b10: load_ext = unsigned_q ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_mem && !misaligned) state_next = S_REQ;
                    else                       state_next = S_DONE;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid_i || timeout_hit) state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wmask_o <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            err_o       <= 1'b0;
            wait_cnt    <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            store_q     <= 1'b0;
            off_q       <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        size_q     <= size_i;
                        unsigned_q <= unsigned_i;
                        store_q    <= is_store;
                        off_q      <= result_i[2:0];
                        wait_cnt   <= '0;
                        if (is_mem && !misaligned) begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= is_store;
                            mem_addr_o  <= {result_i[63:3], 3'b000};
                            mem_wdata_o <= mdata_i << {result_i[2:0], 3'b000};
                            mem_wmask_o <= base_mask << result_i[2:0];
                        end else begin
                            out_valid_o <= 1'b1;
                            err_o       <= is_mem;
                            out_data_o  <= is_mem ? 64'd0 : result_i;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) mem_req_o <= 1'b0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // Response takes priority over a timeout in the same cycle.
                    if (mem_rvalid_i) begin
                        out_valid_o <= 1'b1;
                        err_o       <= 1'b0;
                        out_data_o  <= store_q ? 64'd0 : load_ext;
                    end else if (timeout_hit) begin
                        out_valid_o <= 1'b1;
                        err_o       <= 1'b1;
                        out_data_o  <= '0;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        err_o       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
module tb_ysyx_22040895_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [1:0]  sl_i = '0;
    logic [1:0]  size_i = '0;
    logic        unsigned_i = 1'b0;
    logic [63:0] result_i = '0;
    logic [63:0] mdata_i = '0;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wmask_o;
    logic        mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [63:0] out_data_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22040895_lsu #(.TIMEOUT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .sl_i(sl_i), .size_i(size_i), .unsigned_i(unsigned_i),
        .result_i(result_i), .mdata_i(mdata_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".in_ready"},  64'(in_ready_o),  64'd1);
        chk({tag, ".mem_req"},   64'(mem_req_o),   64'd0);
        chk({tag, ".mem_we"},    64'(mem_we_o),    64'd0);
        chk({tag, ".out_valid"}, 64'(out_valid_o), 64'd0);
        chk({tag, ".err"},       64'(err_o),       64'd0);
        chk({tag, ".addr"},      mem_addr_o,       64'd0);
        chk({tag, ".wdata"},     mem_wdata_o,      64'd0);
        chk({tag, ".wmask"},     64'(mem_wmask_o), 64'd0);
        chk({tag, ".out_data"},  out_data_o,       64'd0);
    endtask

    // Present one op for exactly the accepting edge.
    task automatic issue(input logic [1:0] sl, input logic [1:0] sz, input logic uns,
                         input logic [63:0] res, input logic [63:0] md);
        in_valid_i = 1'b1; sl_i = sl; size_i = sz; unsigned_i = uns;
        result_i = res; mdata_i = md;
        step();
        in_valid_i = 1'b0; result_i = '0; mdata_i = '0;
    endtask

    // Immediate grant, response one cycle later.
    task automatic respond(input logic [63:0] rd);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = rd;
        step();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic handshake();
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [1:0] sz, input logic uns,
                              input logic [63:0] addr, input logic [63:0] rd,
                              input logic [63:0] exp);
        issue(2'b01, sz, uns, addr, '0);
        respond(rd);
        chk({tag, ".valid"}, 64'(out_valid_o), 64'd1);
        chk({tag, ".data"},  out_data_o,       exp);
        chk({tag, ".err"},   64'(err_o),       64'd0);
        handshake();
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        chk_reset("reset");

        // Pass-through: valid one cycle after accept, no memory request.
        issue(2'b00, 2'b00, 1'b0, 64'h0000_0000_DEAD_BEEF, '0);
        chk("pt.valid",    64'(out_valid_o), 64'd1);
        chk("pt.data",     out_data_o,       64'h0000_0000_DEAD_BEEF);
        chk("pt.mem_req",  64'(mem_req_o),   64'd0);
        chk("pt.err",      64'(err_o),       64'd0);
        // WBU back-pressure: output held, no new op accepted.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp.valid",    64'(out_valid_o), 64'd1);
            chk("bp.data",     out_data_o,       64'h0000_0000_DEAD_BEEF);
            chk("bp.in_ready", 64'(in_ready_o),  64'd0);
        end
        handshake();
        chk("pt.done_valid", 64'(out_valid_o), 64'd0);
        chk("pt.in_ready",   64'(in_ready_o),  64'd1);

        // lb signed with latency check.
        issue(2'b01, 2'b00, 1'b0, 64'h0000_0000_8000_0003, '0);
        chk("lb.mem_req", 64'(mem_req_o),   64'd1);
        chk("lb.addr",    mem_addr_o,       64'h0000_0000_8000_0000);
        chk("lb.we",      64'(mem_we_o),    64'd0);
        chk("lb.wmask",   64'(mem_wmask_o), 64'h08);
        chk("lb.in_rdy",  64'(in_ready_o),  64'd0);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        chk("lb.req_drop", 64'(mem_req_o),   64'd0);
        chk("lb.early",    64'(out_valid_o), 64'd0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0000_0000_8000_0000;
        step();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        chk("lb.valid", 64'(out_valid_o), 64'd1);
        chk("lb.data",  out_data_o,       64'hFFFF_FFFF_FFFF_FF80);
        handshake();

        load_check("lbu", 2'b00, 1'b1, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'h80);
        load_check("lh",  2'b01, 1'b0, 64'h8000_0006, 64'h8765_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8765);
        load_check("lwu", 2'b10, 1'b1, 64'h8000_0004, 64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF);
        load_check("lw",  2'b10, 1'b0, 64'h8000_0004, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF);
        load_check("ldu", 2'b11, 1'b1, 64'h8000_0000, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210);

        // sw into upper word; response data must be ignored.
        issue(2'b10, 2'b10, 1'b0, 64'h0000_0000_8000_0004, 64'h0000_0000_1122_3344);
        chk("sw.we",    64'(mem_we_o),    64'd1);
        chk("sw.addr",  mem_addr_o,       64'h0000_0000_8000_0000);
        chk("sw.wmask", 64'(mem_wmask_o), 64'hF0);
        chk("sw.wdata", mem_wdata_o,      64'h1122_3344_0000_0000);
        respond(64'hFFFF_FFFF_FFFF_FFFF);
        chk("sw.valid", 64'(out_valid_o), 64'd1);
        chk("sw.data",  out_data_o,       64'd0);
        chk("sw.err",   64'(err_o),       64'd0);
        handshake();

        // ld with a 5-cycle grant stall.
        issue(2'b01, 2'b11, 1'b0, 64'h0000_0000_8000_1008, '0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall.req",   64'(mem_req_o),   64'd1);
            chk("stall.addr",  mem_addr_o,       64'h0000_0000_8000_1008);
            chk("stall.wmask", 64'(mem_wmask_o), 64'hFF);
            chk("stall.valid", 64'(out_valid_o), 64'd0);
        end
        respond(64'h0123_4567_89AB_CDEF);
        chk("stall.data", out_data_o, 64'h0123_4567_89AB_CDEF);
        handshake();

        // Misaligned lw: error, no memory access.
        issue(2'b01, 2'b10, 1'b0, 64'h0000_0000_8000_0002, '0);
        chk("mis.valid", 64'(out_valid_o), 64'd1);
        chk("mis.err",   64'(err_o),       64'd1);
        chk("mis.req",   64'(mem_req_o),   64'd0);
        handshake();
        chk("mis.err_clr", 64'(err_o), 64'd0);

        // Stray response while idle is ignored.
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h55;
        step();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        chk("stray.valid", 64'(out_valid_o), 64'd0);
        chk("stray.ready", 64'(in_ready_o),  64'd1);

        // Timeout: 255 WAIT cycles without a response.
        issue(2'b01, 2'b00, 1'b0, 64'h0, '0);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        repeat (254) step();
        chk("to.before", 64'(out_valid_o), 64'd0);
        step();
        chk("to.valid", 64'(out_valid_o), 64'd1);
        chk("to.err",   64'(err_o),       64'd1);
        chk("to.data",  out_data_o,       64'd0);
        handshake();

        // Response on the timeout cycle wins.
        issue(2'b01, 2'b11, 1'b0, 64'h8, '0);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        repeat (254) step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'hCAFE_F00D_1234_5678;
        step();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        chk("tow.valid", 64'(out_valid_o), 64'd1);
        chk("tow.err",   64'(err_o),       64'd0);
        chk("tow.data",  out_data_o,       64'hCAFE_F00D_1234_5678);
        handshake();

        // Reset in WAIT aborts; late response ignored.
        issue(2'b10, 2'b11, 1'b0, 64'h8000_0010, 64'hAAAA);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset("rstwait");
        mem_rvalid_i = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        chk("rstwait.stray_valid", 64'(out_valid_o), 64'd0);
        chk("rstwait.stray_ready", 64'(in_ready_o),  64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
